// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART transmit feeder.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Drain state machine encoding
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LAUNCH  = 2'b01,
    WAIT_HI = 2'b10,
    WAIT_LO = 2'b11
  } fsm_state_t;

  // Cycles spent waiting for Busy to rise before re-pulsing DATA_VALID
  localparam int RETRY_WAIT = 4;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : byte_fifo
//  Purpose  : Synchronous FIFO with registered FULL/EMPTY/FILL flags and a
//             combinational head-of-queue read port.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_WIDTH-1:0]      WR_DATA,
  input  logic                       WR_EN,
  input  logic                       RD_EN,
  output logic [DATA_WIDTH-1:0]      RD_DATA,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic [$clog2(DEPTH):0]     FILL
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // A write against a full FIFO is dropped even when a pop frees a slot
  assign wr_ok   = WR_EN && !FULL;
  assign rd_ok   = RD_EN && !EMPTY;
  assign RD_DATA = mem[rd_ptr];
  assign FILL    = count;

  // Next occupancy; a simultaneous write and pop leaves it unchanged
  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok) begin
      count_nxt = count + CW'(1);
    end else if (!wr_ok && rd_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Pointers, occupancy and flags; pointers wrap naturally at DEPTH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      FULL   <= 1'b0;
      EMPTY  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      FULL  <= (count_nxt == CW'(DEPTH));
      EMPTY <= (count_nxt == CW'(0));
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_ptr] <= WR_DATA;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_feeder
//  Purpose  : Buffers bytes and launches them one frame at a time into the
//             UART transmitter over the P_DATA/DATA_VALID/Busy handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  WR_DATA,
  input  logic                   WR_EN,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] FILL,
  output logic [DATA_WIDTH-1:0]  TX_P_DATA,
  output logic                   TX_DATA_VALID,
  input  logic                   TX_BUSY,
  output logic                   FRAME_DONE
);

  localparam int RCW = $clog2(RETRY_WAIT + 1);

  fsm_state_t            state;
  logic [RCW-1:0]        retry;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;

  // Pop only from IDLE, and never while a (possibly foreign) frame is busy
  assign pop = (state == IDLE) && !EMPTY && !TX_BUSY;

  byte_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .WR_DATA (WR_DATA),
    .WR_EN   (WR_EN),
    .RD_EN   (pop),
    .RD_DATA (head),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .FILL    (FILL)
  );

  // Drain FSM: launch, wait for Busy to rise (re-pulse on timeout), wait for it to fall
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      retry         <= '0;
      TX_P_DATA     <= '0;
      TX_DATA_VALID <= 1'b0;
      FRAME_DONE    <= 1'b0;
    end else begin
      TX_DATA_VALID <= 1'b0;
      FRAME_DONE    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            // P_DATA is captured here only and held for the whole frame
            TX_P_DATA     <= head;
            retry         <= '0;
            TX_DATA_VALID <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (TX_BUSY) begin
            state <= WAIT_LO;
          end else if (retry == RCW'(RETRY_WAIT - 1)) begin
            retry         <= '0;
            TX_DATA_VALID <= 1'b1;
            state         <= LAUNCH;
          end else begin
            retry <= retry + RCW'(1);
          end
        end
        WAIT_LO: begin
          if (!TX_BUSY) begin
            FRAME_DONE <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
